unified_mem_arbiter: RTL

//  Shares one single-ported unified RAM between instruction fetch (IF) and the memory stage (DM).

---
 rtl/mem_ctrl_pkg.sv | 35 +++
 rtl/mem_arb_pick.sv | 20 ++
 rtl/unified_mem_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the unified memory arbiter: access sizes, FSM states, owners
// and the alignment rule applied to data-side accesses.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10
   } size_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CMD  = 2'b01,
      WAIT = 2'b10,
      RESP = 2'b11
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_t;

   // Size code 2'b11 has no legal meaning, so it is reported as misaligned.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic r;
      case (size)
         2'b00:   r = 1'b0;
         2'b01:   r = addr_lo[0];
         2'b10:   r = (addr_lo != 2'b00);
         default: r = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational owner selection: DM has priority unless IF has been waiting through
// MAX_CONSEC back-to-back DM grants.
module mem_arb_pick #(
   parameter int MAX_CONSEC = 4,
   parameter int CW         = 3
) (
   input  logic          i_if_req,
   input  logic          i_dm_req,
   input  logic [CW-1:0] i_consec,
   output logic          o_grant_dm,
   output logic          o_grant_if
);

   logic w_dm_allowed;

   assign w_dm_allowed = ~i_if_req | (i_consec < CW'(MAX_CONSEC));
   assign o_grant_dm   = i_dm_req & w_dm_allowed;
   assign o_grant_if   = i_if_req & ~o_grant_dm;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported fixed-latency RAM between instruction fetch and the memory stage,
// one access at a time, with done pulses, pipeline stalls and an anti-starvation counter.
module unified_mem_arbiter
   import mem_ctrl_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MEM_LAT    = 2,
   parameter int MAX_CONSEC = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             if_req,
   input  logic [WIDTH-1:0] if_addr,
   output logic             if_done,
   output logic [WIDTH-1:0] if_rdata,
   input  logic             dm_req,
   input  logic             dm_we,
   input  logic [1:0]       dm_size,
   input  logic [WIDTH-1:0] dm_addr,
   input  logic [WIDTH-1:0] dm_wdata,
   output logic             dm_done,
   output logic [WIDTH-1:0] dm_rdata,
   output logic             dm_misalign,
   output logic             stall_F,
   output logic             stall_M,
   output logic             mem_en,
   output logic             mem_we,
   output logic [1:0]       mem_size,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic [1:0]       dbg_state
);

   localparam int CW = $clog2(MAX_CONSEC + 1);
   localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   // Handshake: a requester raises *_req with stable fields and holds both until its *_done
   // pulse; requests are only sampled in IDLE, and done is a single-cycle pulse in RESP.

   state_t           r_state;
   state_t           w_state_nx;
   owner_t           r_owner;
   logic [WIDTH-1:0] r_addr;
   logic             r_we;
   logic [1:0]       r_size;
   logic [WIDTH-1:0] r_wdata;
   logic             r_misalign;
   logic [LW-1:0]    r_lat_cnt;
   logic [CW-1:0]    r_consec;
   logic [WIDTH-1:0] r_if_rdata;
   logic [WIDTH-1:0] r_dm_rdata;

   logic             w_grant_dm;
   logic             w_grant_if;
   logic             w_dm_misalign;
   logic             w_in_idle;
   logic             w_in_resp;

   mem_arb_pick #(
      .MAX_CONSEC (MAX_CONSEC),
      .CW         (CW)
   ) u_pick (
      .i_if_req   (if_req),
      .i_dm_req   (dm_req),
      .i_consec   (r_consec),
      .o_grant_dm (w_grant_dm),
      .o_grant_if (w_grant_if)
   );

   assign w_dm_misalign = is_misaligned(dm_size, dm_addr[1:0]);
   assign w_in_idle     = (r_state == IDLE);
   assign w_in_resp     = (r_state == RESP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Misaligned DM accesses skip the RAM entirely and answer from IDLE straight to RESP.
   always_comb begin
      w_state_nx = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_grant_dm) begin
               w_state_nx = w_dm_misalign ? RESP : CMD;
            end else if (w_grant_if) begin
               w_state_nx = CMD;
            end
         end
         CMD:  w_state_nx = WAIT;
         WAIT: begin
            if (r_lat_cnt == '0) begin
               w_state_nx = RESP;
            end
         end
         RESP: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_owner    <= OWN_IF;
         r_addr     <= '0;
         r_we       <= 1'b0;
         r_size     <= 2'b00;
         r_wdata    <= '0;
         r_misalign <= 1'b0;
         r_lat_cnt  <= '0;
         r_consec   <= '0;
         r_if_rdata <= '0;
         r_dm_rdata <= '0;
      end else begin
         if (w_in_idle && (w_grant_dm || w_grant_if)) begin
            r_owner    <= w_grant_dm ? OWN_DM : OWN_IF;
            r_addr     <= w_grant_dm ? dm_addr : if_addr;
            r_we       <= w_grant_dm & dm_we;
            r_size     <= w_grant_dm ? dm_size : SZ_W;
            r_wdata    <= w_grant_dm ? dm_wdata : '0;
            r_misalign <= w_grant_dm & w_dm_misalign;
            if (w_grant_dm && w_dm_misalign) begin
               r_dm_rdata <= '0;
            end
            // Only DM wins taken over a waiting IF count toward forcing an IF grant.
            if (w_grant_dm && if_req) begin
               if (r_consec != CW'(MAX_CONSEC)) begin
                  r_consec <= r_consec + CW'(1);
               end
            end else begin
               r_consec <= '0;
            end
         end

         if (r_state == CMD) begin
            r_lat_cnt <= LW'(MEM_LAT - 1);
         end else if ((r_state == WAIT) && (r_lat_cnt != '0)) begin
            r_lat_cnt <= r_lat_cnt - LW'(1);
         end

         if ((r_state == WAIT) && (r_lat_cnt == '0)) begin
            if (r_owner == OWN_IF) begin
               r_if_rdata <= mem_rdata;
            end else begin
               r_dm_rdata <= mem_rdata;
            end
         end
      end
   end

   assign if_done     = w_in_resp && (r_owner == OWN_IF);
   assign dm_done     = w_in_resp && (r_owner == OWN_DM);
   assign dm_misalign = dm_done & r_misalign;
   assign if_rdata    = r_if_rdata;
   assign dm_rdata    = r_dm_rdata;

   assign stall_F     = if_req & ~if_done;
   assign stall_M     = dm_req & ~dm_done;

   assign mem_en      = (r_state == CMD);
   assign mem_we      = mem_en & r_we;
   assign mem_size    = r_size;
   assign mem_addr    = r_addr;
   assign mem_wdata   = r_wdata;

   assign dbg_state   = r_state;

endmodule
